// File: rtl/spi_seq_pkg.sv
// Shared types and defaults for the scan-select SPI sequencer.
package spi_seq_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 6;
  // Longest transfer the fabric accepts; longer requests are clamped to this.
  localparam int LEN_MAX    = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_LO,
    S_ADDR_HI,
    S_ADDR_TAIL,
    S_SWITCH,
    S_DATA_LO,
    S_DATA_HI,
    S_DONE
  } state_e;

endpackage

// File: rtl/spi_phase_timer.sv
// Phase timer: each sequencer phase lasts CLK_DIV Master_clk cycles.
// Reloaded on every state change; phase_done_o is high on the last cycle.
module spi_phase_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic Master_clk,
  input  logic RESET,
  input  logic load_i,
  output logic phase_done_o
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: reload on phase entry, otherwise count down to zero and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge Master_clk or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_done_o = (cnt_q == '0);

endmodule

// File: rtl/spi_scan_sequencer.sv
// Master-side sequencer for the 32-slave scan-select SPI fabric: programs the
// slave address (REGSEL high), then shifts up to 32 data bits MSB-first and
// returns the captured bits. The last programmed address is cached so repeat
// accesses to the same slave skip the address phase.
module spi_scan_sequencer
  import spi_seq_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int CLK_DIV = 2
) (
  input  logic              Master_clk,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              spi_regsel,
  output logic              spi_sclk,
  output logic              spi_sin,
  input  logic              spi_sout
);

  localparam int IDX_W  = $clog2(DATA_W);
  localparam int AIDX_W = $clog2(ADDR_W);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   cap_q, cap_d;
  logic [LEN_W-1:0]    bit_q, bit_d;
  logic [ADDR_W-1:0]   cache_addr_q, cache_addr_d;
  logic                cache_vld_q, cache_vld_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                regsel_q, regsel_d;
  logic                sclk_q, sclk_d;
  logic                sin_q, sin_d;

  logic                phase_done;
  logic                timer_load;
  logic [LEN_W-1:0]    len_clamp;
  logic [AIDX_W-1:0]   aidx;
  logic [IDX_W-1:0]    didx;

  assign len_clamp  = (req_len > LEN_W'(LEN_MAX)) ? LEN_W'(LEN_MAX) : req_len;
  assign timer_load = (state_d != state_q);

  spi_phase_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .Master_clk  (Master_clk),
    .RESET       (RESET),
    .load_i      (timer_load),
    .phase_done_o(phase_done)
  );

  // Next-state, datapath and next pin values. Pins are decoded from the
  // next state so the registered pins change on the same edge as the state.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    wdata_d      = wdata_q;
    cap_d        = cap_q;
    bit_d        = bit_q;
    cache_addr_d = cache_addr_q;
    cache_vld_d  = cache_vld_q;
    rdata_d      = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          len_d   = len_clamp;
          wdata_d = req_wdata;
          cap_d   = '0;
          bit_d   = '0;
          if (cache_vld_q && (cache_addr_q == req_addr)) begin
            state_d = (len_clamp == '0) ? S_DONE : S_DATA_LO;
          end else begin
            state_d = S_ADDR_LO;
          end
        end
      end
      S_ADDR_LO: begin
        if (phase_done) state_d = S_ADDR_HI;
      end
      S_ADDR_HI: begin
        if (phase_done) begin
          if (bit_q == LEN_W'(ADDR_W - 1)) begin
            bit_d   = '0;
            state_d = S_ADDR_TAIL;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = S_ADDR_LO;
          end
        end
      end
      S_ADDR_TAIL: begin
        if (phase_done) begin
          cache_addr_d = addr_q;
          cache_vld_d  = 1'b1;
          state_d      = S_SWITCH;
        end
      end
      // Address-only requests also pass through SWITCH so the address phase
      // always costs 12 half-periods regardless of length.
      S_SWITCH: begin
        if (phase_done) state_d = (len_q == '0) ? S_DONE : S_DATA_LO;
      end
      S_DATA_LO: begin
        if (phase_done) begin
          cap_d   = {cap_q[DATA_W-2:0], spi_sout};
          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (phase_done) begin
          if ((bit_q + 1'b1) == len_q) begin
            state_d = S_DONE;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = S_DATA_LO;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_DONE) rdata_d = cap_d;
    rsp_valid_d = (state_d == S_DONE);

    aidx     = AIDX_W'(ADDR_W - 1) - bit_d[AIDX_W-1:0];
    didx     = len_d[IDX_W-1:0] - 1'b1 - bit_d[IDX_W-1:0];
    regsel_d = (state_d == S_ADDR_LO) || (state_d == S_ADDR_HI) || (state_d == S_ADDR_TAIL);
    sclk_d   = (state_d == S_ADDR_HI) || (state_d == S_DATA_HI);
    unique case (state_d)
      S_ADDR_LO:            sin_d = addr_d[aidx];
      S_DATA_LO:            sin_d = wdata_d[didx];
      S_ADDR_HI, S_DATA_HI: sin_d = sin_q;
      default:              sin_d = 1'b0;
    endcase
  end

  // State, datapath and pin registers; reset idles all pins and drops the cache.
  always_ff @(posedge Master_clk or negedge RESET) begin
    if (!RESET) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      wdata_q      <= '0;
      cap_q        <= '0;
      bit_q        <= '0;
      cache_addr_q <= '0;
      cache_vld_q  <= 1'b0;
      rdata_q      <= '0;
      rsp_valid_q  <= 1'b0;
      regsel_q     <= 1'b0;
      sclk_q       <= 1'b0;
      sin_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      wdata_q      <= wdata_d;
      cap_q        <= cap_d;
      bit_q        <= bit_d;
      cache_addr_q <= cache_addr_d;
      cache_vld_q  <= cache_vld_d;
      rdata_q      <= rdata_d;
      rsp_valid_q  <= rsp_valid_d;
      regsel_q     <= regsel_d;
      sclk_q       <= sclk_d;
      sin_q        <= sin_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign spi_regsel = regsel_q;
  assign spi_sclk   = sclk_q;
  assign spi_sin    = sin_q;

endmodule

// File: tb/tb_spi_scan_sequencer.sv
// Bench for spi_scan_sequencer: two instances (CLK_DIV=1 and CLK_DIV=2), a
// pin monitor acting as the fabric/slave, and a transaction-level model of
// latency, address cache, sent bits and returned data.
module tb_spi_scan_sequencer;

  localparam int NI     = 2;
  localparam int BUDGET = 4000;

  logic        Master_clk = 1'b0;
  logic        RESET      = 1'b0;

  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic [4:0]  req_addr   [NI];
  logic [5:0]  req_len    [NI];
  logic [31:0] req_wdata  [NI];
  logic        rsp_valid  [NI];
  logic [31:0] rsp_rdata  [NI];
  logic        busy       [NI];
  logic        spi_regsel [NI];
  logic        spi_sclk   [NI];
  logic        spi_sin    [NI];
  logic        spi_sout   [NI];

  // Pin-level observations (written only by the monitor).
  int          addr_cnt  [NI];
  int          data_cnt  [NI];
  int          rs_cnt    [NI];
  int          viol      [NI];
  logic [63:0] addr_hist [NI];
  logic [63:0] data_hist [NI];
  logic        sclk_prev [NI];
  logic        rs_prev   [NI];

  // Slave response description (written by the stimulus tasks).
  int          sl_base [NI];
  int          sl_len  [NI];
  logic [31:0] sl_val  [NI];

  // Reference model of the address cache.
  bit          cvld  [NI];
  logic [4:0]  caddr [NI];

  int n_vec = 0;
  int n_err = 0;

  always #5 Master_clk = ~Master_clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    spi_scan_sequencer #(
      .ADDR_W (5),
      .DATA_W (32),
      .LEN_W  (6),
      .CLK_DIV(g + 1)
    ) u_dut (
      .Master_clk(Master_clk),
      .RESET     (RESET),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_addr  (req_addr[g]),
      .req_len   (req_len[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .busy      (busy[g]),
      .spi_regsel(spi_regsel[g]),
      .spi_sclk  (spi_sclk[g]),
      .spi_sin   (spi_sin[g]),
      .spi_sout  (spi_sout[g])
    );
  end

  // Fabric/slave model: records SIN on each SCLK rise, counts REGSEL cycles,
  // flags REGSEL and SCLK moving together, and drives SOUT MSB-first.
  always @(negedge Master_clk) begin
    for (int g = 0; g < NI; g++) begin
      int idx;
      if (spi_sclk[g] && !sclk_prev[g]) begin
        if (spi_regsel[g]) begin
          addr_hist[g] = {addr_hist[g][62:0], spi_sin[g]};
          addr_cnt[g]++;
        end else begin
          data_hist[g] = {data_hist[g][62:0], spi_sin[g]};
          data_cnt[g]++;
        end
      end
      if (spi_regsel[g]) rs_cnt[g]++;
      if ((spi_regsel[g] !== rs_prev[g]) && (spi_sclk[g] !== sclk_prev[g])) viol[g]++;
      sclk_prev[g] = spi_sclk[g];
      rs_prev[g]   = spi_regsel[g];
      idx = data_cnt[g] - sl_base[g];
      if (idx >= 0 && idx < sl_len[g]) spi_sout[g] = sl_val[g][sl_len[g] - 1 - idx];
      else                             spi_sout[g] = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One host transaction on instance g, checked against the model.
  task automatic do_op(input int g, input logic [4:0] a, input int len,
                       input logic [31:0] wd, input logic [31:0] sv, input bit inject);
    int L, D, lat, a0, d0, r0, v0, exp_lat;
    bit A;
    logic [63:0] m;
    L = (len > 32) ? 32 : len;
    D = g + 1;
    A = !(cvld[g] && caddr[g] == a);
    exp_lat = D * ((A ? 12 : 0) + 2 * L);
    m = (L == 0) ? 64'd0 : ((64'd1 << L) - 64'd1);
    a0 = addr_cnt[g]; d0 = data_cnt[g]; r0 = rs_cnt[g]; v0 = viol[g];
    sl_base[g] = data_cnt[g]; sl_val[g] = sv; sl_len[g] = L;
    req_addr[g] = a; req_len[g] = 6'(len); req_wdata[g] = wd; req_valid[g] = 1'b1;
    @(posedge Master_clk); #1;
    req_valid[g] = 1'b0; req_addr[g] = ~a; req_len[g] = 6'($urandom); req_wdata[g] = ~wd;
    chk("busy_after_accept", busy[g], 1);
    lat = 0;
    while (!rsp_valid[g] && lat < BUDGET) begin
      if (inject) begin
        req_valid[g] = (lat >= 2 && lat < 6);
        req_addr[g]  = 5'd3;
        if (lat >= 2 && lat < 6) chk("ready_while_busy", req_ready[g], 0);
      end
      @(posedge Master_clk); #1;
      lat++;
    end
    req_valid[g] = 1'b0;
    chk("latency", lat, exp_lat);
    chk("rdata", rsp_rdata[g], {32'd0, sv} & m);
    chk("addr_pulses", addr_cnt[g] - a0, A ? 5 : 0);
    if (A) chk("addr_bits", addr_hist[g][4:0], a);
    chk("data_pulses", data_cnt[g] - d0, L);
    if (L > 0) chk("data_bits", data_hist[g] & m, {32'd0, wd} & m);
    chk("regsel_cycles", rs_cnt[g] - r0, A ? 11 * D : 0);
    chk("regsel_sclk_same_edge", viol[g] - v0, 0);
    @(posedge Master_clk); #1;
    chk("rsp_one_cycle", rsp_valid[g], 0);
    chk("ready_after", req_ready[g], 1);
    chk("busy_after", busy[g], 0);
    if (inject) begin
      repeat (4) begin
        @(posedge Master_clk); #1;
        chk("no_extra_rsp", rsp_valid[g], 0);
      end
      chk("ignored_req_idle", busy[g], 0);
    end
    if (A) begin
      cvld[g]  = 1'b1;
      caddr[g] = a;
    end
  endtask

  task automatic check_idle_pins(input string tag);
    for (int g = 0; g < NI; g++) begin
      chk({tag, "_regsel"}, spi_regsel[g], 0);
      chk({tag, "_sclk"},   spi_sclk[g],   0);
      chk({tag, "_sin"},    spi_sin[g],    0);
      chk({tag, "_busy"},   busy[g],       0);
      chk({tag, "_ready"},  req_ready[g],  1);
      chk({tag, "_rvalid"}, rsp_valid[g],  0);
      chk({tag, "_rdata"},  rsp_rdata[g],  0);
    end
  endtask

  // Start a long transfer on instance 0 and reset it during the third data bit.
  task automatic reset_midop();
    int base, guard;
    base = data_cnt[0];
    sl_base[0] = base; sl_val[0] = $urandom; sl_len[0] = 10;
    req_addr[0] = 5'd9; req_len[0] = 6'd10; req_wdata[0] = $urandom; req_valid[0] = 1'b1;
    @(posedge Master_clk); #1;
    req_valid[0] = 1'b0;
    guard = 0;
    while ((data_cnt[0] - base) < 2 && guard < 500) begin
      @(posedge Master_clk); #1;
      guard++;
    end
    chk("reset_reach_bit3", (guard < 500), 1);
    chk("reset_in_data_phase", busy[0], 1);
    #2 RESET = 1'b0;
    #1;
    check_idle_pins("midop_reset");
    cvld[0] = 1'b0;
    cvld[1] = 1'b0;
    repeat (2) @(posedge Master_clk);
    @(negedge Master_clk) RESET = 1'b1;
    @(posedge Master_clk); #1;
  endtask

  initial begin
    for (int g = 0; g < NI; g++) begin
      req_valid[g] = 1'b0; req_addr[g] = '0; req_len[g] = '0; req_wdata[g] = '0;
      addr_cnt[g] = 0; data_cnt[g] = 0; rs_cnt[g] = 0; viol[g] = 0;
      addr_hist[g] = '0; data_hist[g] = '0; sclk_prev[g] = 1'b0; rs_prev[g] = 1'b0;
      sl_base[g] = 0; sl_len[g] = 0; sl_val[g] = '0;
      cvld[g] = 1'b0; caddr[g] = '0;
    end
    RESET = 1'b0;
    repeat (3) @(posedge Master_clk);
    #1;
    check_idle_pins("reset");
    @(negedge Master_clk) RESET = 1'b1;
    @(posedge Master_clk); #1;

    // Address + data at D=1, then a cache hit to the same slave.
    do_op(0, 5'b10110, 8, 32'h0000_00A5, 32'h0000_003C, 1'b0);
    do_op(0, 5'd22, 4, 32'h0000_0009, $urandom, 1'b0);
    // Address-only at D=2.
    do_op(1, 5'd31, 0, $urandom, $urandom, 1'b0);
    // Cache hit with zero length: response on the cycle after accept.
    do_op(1, 5'd31, 0, $urandom, $urandom, 1'b0);
    // Clamp to full width with SOUT held high.
    do_op(0, 5'd7, 40, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    // Requests while busy are ignored.
    do_op(0, 5'd7, 12, $urandom, $urandom, 1'b1);
    // Reset mid-transfer, then the same slave needs a full address phase.
    reset_midop();
    do_op(0, 5'd9, 10, $urandom, $urandom, 1'b0);

    // Random traffic over a few slaves so hits and misses both occur.
    for (int n = 0; n < 40; n++) begin
      do_op(int'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            int'($urandom_range(0, 40)), $urandom, $urandom, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
